exe_stage: RTL and testbench

// - Execute stage of the 5-stage ARM core; consumes the decode->execute register bundle (pc, control, val_rn/val_rm, operand fields).
// - Computes Val2 and the ALU result. Owns the NZCV status register and feeds it back to decode.
// - Drives branch_taken/branch_addr back to fetch and to the decode->execute register flush.
// - Registers results into the execute->memory bundle, one-cycle latency, holding on freeze.

---
 rtl/exe_stage_pkg.sv | 65 ++++++
 rtl/exe_stage_val2_generator.sv | 38 +++
 rtl/exe_stage.sv | 150 +++++++++++++++
 tb/tb_exe_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_pkg.sv
// Shared widths, encodings and payload types for the execute stage.
// Contents: data/address/register-address widths, ALU command and shift-type
// encodings, forward-select encoding, NZCV and execute->memory bundle structs,
// and a rotate-right helper.
package exe_stage_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REGA_W   = 4;
  localparam int unsigned CMD_W    = 4;
  localparam int unsigned SHOP_W   = 12;
  localparam int unsigned SIMM_W   = 24;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned SHAMT_W  = 5;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  typedef enum logic [SEL_W-1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10,
    FWD_RSV = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_val;
    logic [REGA_W-1:0] dest_reg;
    logic              mem_read;
    logic              mem_write;
    logic              wb_enable;
  } exe_mem_t;

  // Rotate right; an amount of zero returns x unchanged (left shift by width is zero).
  function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] x,
                                            input logic [SHAMT_W-1:0] r);
    return (x >> r) | (x << ((SHAMT_W + 1)'(DATA_W) - {1'b0, r}));
  endfunction

endpackage

// File: rtl/exe_stage_val2_generator.sv
// Combinational operand-2 (Val2) generator.
// Ports: immediate (I bit), mem_op (load/store), shift_operand[11:0],
//        val_rm (possibly forwarded Rm), val2_c (resulting operand 2).
module exe_stage_val2_generator
  import exe_stage_pkg::*;
(
  input  logic              immediate,
  input  logic              mem_op,
  input  logic [SHOP_W-1:0] shift_operand,
  input  logic [DATA_W-1:0] val_rm,
  output logic [DATA_W-1:0] val2_c
);

  logic [SHAMT_W-1:0] rot_amt;
  logic [SHAMT_W-1:0] sh_amt;
  shift_e             sh_type;

  always_comb begin
    rot_amt = {shift_operand[11:8], 1'b0};
    sh_amt  = shift_operand[11:7];
    sh_type = shift_e'(shift_operand[6:5]);
    val2_c  = '0;
    if (immediate) begin
      val2_c = ror(DATA_W'(shift_operand[7:0]), rot_amt);
    end else if (mem_op) begin
      // Load/store offset is the raw 12-bit field, zero-extended.
      val2_c = DATA_W'(shift_operand);
    end else begin
      case (sh_type)
        SH_LSL:  val2_c = val_rm << sh_amt;
        SH_LSR:  val2_c = val_rm >> sh_amt;
        SH_ASR:  val2_c = DATA_W'($signed(val_rm) >>> sh_amt);
        default: val2_c = ror(val_rm, sh_amt);
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, Val2, ALU, NZCV register, branch target
// and the execute->memory pipeline register (one-cycle latency, holds on freeze).
// Optional feature: EXE_FORWARDING_EN enables the sel_src1/sel_src2 operand muxes;
// without it the forwarding ports are accepted but ignored.
// Ports: clk, rst (sync active-low), freeze; decode bundle (pc_in, control,
//        execute_command, val_rn/val_rm, immediate, signed_imm, shift_operand,
//        dest_reg_in); forwarding selects/values; status_out (NZCV);
//        branch_taken/branch_addr (combinational); registered memory bundle.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              wb_enable_in,
  input  logic              branch_taken_in,
  input  logic              status_write_enable_in,
  input  logic [CMD_W-1:0]  execute_command,
  input  logic [DATA_W-1:0] val_rn,
  input  logic [DATA_W-1:0] val_rm,
  input  logic              immediate,
  input  logic [SIMM_W-1:0] signed_imm,
  input  logic [SHOP_W-1:0] shift_operand,
  input  logic [REGA_W-1:0] dest_reg_in,
  input  logic [SEL_W-1:0]  sel_src1,
  input  logic [SEL_W-1:0]  sel_src2,
  input  logic [DATA_W-1:0] mem_fwd_val,
  input  logic [DATA_W-1:0] wb_fwd_val,
  output logic [3:0]        status_out,
  output logic              branch_taken,
  output logic [ADDR_W-1:0] branch_addr,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] store_val_out,
  output logic [REGA_W-1:0] dest_reg_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              wb_enable_out
);

  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic [DATA_W-1:0] val2;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] res;
  nzcv_t             nzcv_q;
  nzcv_t             nzcv_d;
  exe_mem_t          pipe_q;
  exe_mem_t          pipe_d;
  exe_cmd_e          cmd;

  // Operand source selection.
`ifdef EXE_FORWARDING_EN
  always_comb begin
    case (fwd_sel_e'(sel_src1))
      FWD_MEM: src1 = mem_fwd_val;
      FWD_WB:  src1 = wb_fwd_val;
      default: src1 = val_rn;
    endcase
    case (fwd_sel_e'(sel_src2))
      FWD_MEM: src2 = mem_fwd_val;
      FWD_WB:  src2 = wb_fwd_val;
      default: src2 = val_rm;
    endcase
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{sel_src1, sel_src2, mem_fwd_val, wb_fwd_val};
  assign src1 = val_rn;
  assign src2 = val_rm;
`endif

  exe_stage_val2_generator u_val2 (
    .immediate     (immediate),
    .mem_op        (mem_read_in | mem_write_in),
    .shift_operand (shift_operand),
    .val_rm        (src2),
    .val2_c        (val2)
  );

  // Branch target: pc+4 plus word-scaled sign-extended offset.
  assign branch_taken = branch_taken_in;
  assign branch_addr  = pc_in + {{(ADDR_W - SIMM_W - 2){signed_imm[SIMM_W-1]}}, signed_imm, 2'b00};

  // ALU and next flags; carry-in always comes from the registered C.
  always_comb begin
    cmd      = exe_cmd_e'(execute_command);
    sum      = '0;
    res      = '0;
    nzcv_d   = nzcv_q;
    case (cmd)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_AND: res = src1 & val2;
      CMD_ORR: res = src1 | val2;
      CMD_EOR: res = src1 ^ val2;
      CMD_ADD, CMD_ADC: begin
        sum = {1'b0, src1} + {1'b0, val2}
            + (DATA_W + 1)'((cmd == CMD_ADC) ? nzcv_q.c : 1'b0);
        res = sum[DATA_W-1:0];
        nzcv_d.c = sum[DATA_W];
        nzcv_d.v = (src1[DATA_W-1] == val2[DATA_W-1]) && (res[DATA_W-1] != src1[DATA_W-1]);
      end
      CMD_SUB, CMD_SBC: begin
        // rn + ~val2 + 1 (SUB) or + C (SBC); carry out is NOT borrow.
        sum = {1'b0, src1} + {1'b0, ~val2}
            + (DATA_W + 1)'((cmd == CMD_SUB) ? 1'b1 : nzcv_q.c);
        res = sum[DATA_W-1:0];
        nzcv_d.c = sum[DATA_W];
        nzcv_d.v = (src1[DATA_W-1] == ~val2[DATA_W-1]) && (res[DATA_W-1] != src1[DATA_W-1]);
      end
      default: res = '0;
    endcase
    nzcv_d.n = res[DATA_W-1];
    nzcv_d.z = (res == '0);
  end

  always_comb begin
    pipe_d.alu_result = res;
    pipe_d.store_val  = src2;
    pipe_d.dest_reg   = dest_reg_in;
    pipe_d.mem_read   = mem_read_in;
    pipe_d.mem_write  = mem_write_in;
    pipe_d.wb_enable  = wb_enable_in;
  end

  // Pipeline and status registers; reset dominates freeze.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe_q <= '0;
      nzcv_q <= '0;
    end else if (!freeze) begin
      pipe_q <= pipe_d;
      if (status_write_enable_in) begin
        nzcv_q <= nzcv_d;
      end
    end
  end

  assign status_out     = nzcv_q;
  assign alu_result_out = pipe_q.alu_result;
  assign store_val_out  = pipe_q.store_val;
  assign dest_reg_out   = pipe_q.dest_reg;
  assign mem_read_out   = pipe_q.mem_read;
  assign mem_write_out  = pipe_q.mem_write;
  assign wb_enable_out  = pipe_q.wb_enable;

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic [31:0] pc_in;
  logic        mem_read_in, mem_write_in, wb_enable_in;
  logic        branch_taken_in, status_write_enable_in;
  logic [3:0]  execute_command;
  logic [31:0] val_rn, val_rm;
  logic        immediate;
  logic [23:0] signed_imm;
  logic [11:0] shift_operand;
  logic [3:0]  dest_reg_in;
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] mem_fwd_val, wb_fwd_val;
  logic [3:0]  status_out;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] alu_result_out, store_val_out;
  logic [3:0]  dest_reg_out;
  logic        mem_read_out, mem_write_out, wb_enable_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .wb_enable_in(wb_enable_in),
    .branch_taken_in(branch_taken_in), .status_write_enable_in(status_write_enable_in),
    .execute_command(execute_command), .val_rn(val_rn), .val_rm(val_rm),
    .immediate(immediate), .signed_imm(signed_imm), .shift_operand(shift_operand),
    .dest_reg_in(dest_reg_in), .sel_src1(sel_src1), .sel_src2(sel_src2),
    .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val), .status_out(status_out),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .alu_result_out(alu_result_out), .store_val_out(store_val_out),
    .dest_reg_out(dest_reg_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .wb_enable_out(wb_enable_out)
  );

  task automatic set_idle();
    rst = 1'b1; freeze = 1'b0; pc_in = '0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; wb_enable_in = 1'b0;
    branch_taken_in = 1'b0; status_write_enable_in = 1'b0;
    execute_command = 4'b0000; val_rn = '0; val_rm = '0; immediate = 1'b0;
    signed_imm = '0; shift_operand = '0; dest_reg_in = '0;
    sel_src1 = 2'b00; sel_src2 = 2'b00; mem_fwd_val = '0; wb_fwd_val = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
    n_checks++; if (alu_result_out !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected %h", alu_result_out, 32'h0); end
    n_checks++; if (store_val_out !== 32'h0) begin n_fail++; $display("FAIL reset_store: got %h expected %h", store_val_out, 32'h0); end
    n_checks++; if ({dest_reg_out, mem_read_out, mem_write_out, wb_enable_out} !== 7'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected %h", {dest_reg_out, mem_read_out, mem_write_out, wb_enable_out}, 7'h0); end
    n_checks++; if (status_out !== 4'b0000) begin n_fail++; $display("FAIL reset_nzcv: got %b expected %b", status_out, 4'b0000); end
  endtask

  task automatic test_add();
    set_idle();
    execute_command = 4'b0010; val_rn = 32'd5; immediate = 1'b1; shift_operand = 12'h0FF;
    dest_reg_in = 4'd3; wb_enable_in = 1'b1;
    step();
    n_checks++; if (alu_result_out !== 32'h104) begin n_fail++; $display("FAIL add_result: got %h expected %h", alu_result_out, 32'h104); end
    n_checks++; if (dest_reg_out !== 4'd3 || wb_enable_out !== 1'b1) begin n_fail++; $display("FAIL add_ctrl: got %h/%b expected 3/1", dest_reg_out, wb_enable_out); end
    n_checks++; if (status_out !== 4'b0000) begin n_fail++; $display("FAIL add_nzcv_hold: got %b expected %b", status_out, 4'b0000); end
  endtask

  task automatic test_sub_adc();
    set_idle();
    execute_command = 4'b0100; status_write_enable_in = 1'b1;
    val_rn = 32'd3; val_rm = 32'd3; shift_operand = 12'h000;
    step();
    n_checks++; if (alu_result_out !== 32'h0) begin n_fail++; $display("FAIL sub_result: got %h expected %h", alu_result_out, 32'h0); end
    n_checks++; if (status_out !== 4'b0110) begin n_fail++; $display("FAIL sub_nzcv: got %b expected %b", status_out, 4'b0110); end
    // ADC with flag write: carry-in must be the pre-edge C=1.
    execute_command = 4'b0011; val_rn = 32'd1; immediate = 1'b1; shift_operand = 12'h001;
    step();
    n_checks++; if (alu_result_out !== 32'd3) begin n_fail++; $display("FAIL adc_result: got %h expected %h", alu_result_out, 32'd3); end
    n_checks++; if (status_out !== 4'b0000) begin n_fail++; $display("FAIL adc_nzcv: got %b expected %b", status_out, 4'b0000); end
    // SBC 10 - 4 - !C(=1) = 5; flags N0 Z0 C1 V0.
    execute_command = 4'b0101; val_rn = 32'd10; shift_operand = 12'h004;
    step();
    n_checks++; if (alu_result_out !== 32'd5) begin n_fail++; $display("FAIL sbc_result: got %h expected %h", alu_result_out, 32'd5); end
    n_checks++; if (status_out !== 4'b0010) begin n_fail++; $display("FAIL sbc_nzcv: got %b expected %b", status_out, 4'b0010); end
  endtask

  task automatic test_overflow();
    set_idle();
    execute_command = 4'b0010; status_write_enable_in = 1'b1;
    val_rn = 32'h7FFF_FFFF; immediate = 1'b1; shift_operand = 12'h001;
    step();
    n_checks++; if (alu_result_out !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_result: got %h expected %h", alu_result_out, 32'h8000_0000); end
    n_checks++; if (status_out !== 4'b1001) begin n_fail++; $display("FAIL ovf_nzcv: got %b expected %b", status_out, 4'b1001); end
    // Logical op with S updates N,Z only: EOR 0xF0 ^ 0xF0 = 0 -> N0 Z1, C0 V1 kept.
    execute_command = 4'b1000; val_rn = 32'hF0; shift_operand = 12'h0F0;
    step();
    n_checks++; if (alu_result_out !== 32'h0) begin n_fail++; $display("FAIL eor_result: got %h expected %h", alu_result_out, 32'h0); end
    n_checks++; if (status_out !== 4'b0101) begin n_fail++; $display("FAIL eor_nzcv: got %b expected %b", status_out, 4'b0101); end
  endtask

  task automatic test_val2();
    set_idle();
    execute_command = 4'b0001; immediate = 1'b1; shift_operand = 12'h4FF;
    step();
    n_checks++; if (alu_result_out !== 32'hFF00_0000) begin n_fail++; $display("FAIL imm_rot: got %h expected %h", alu_result_out, 32'hFF00_0000); end
    immediate = 1'b0; val_rm = 32'h8000_0000; shift_operand = 12'h240;
    step();
    n_checks++; if (alu_result_out !== 32'hF800_0000) begin n_fail++; $display("FAIL asr4: got %h expected %h", alu_result_out, 32'hF800_0000); end
    val_rm = 32'h0000_000F; shift_operand = 12'h260;
    step();
    n_checks++; if (alu_result_out !== 32'hF000_0000) begin n_fail++; $display("FAIL ror4: got %h expected %h", alu_result_out, 32'hF000_0000); end
    val_rm = 32'h8000_0001; shift_operand = 12'h0A0;
    step();
    n_checks++; if (alu_result_out !== 32'h4000_0000) begin n_fail++; $display("FAIL lsr1: got %h expected %h", alu_result_out, 32'h4000_0000); end
    execute_command = 4'b1001; val_rm = 32'h0000_00FF; shift_operand = 12'h200;
    step();
    n_checks++; if (alu_result_out !== 32'hFFFF_F00F) begin n_fail++; $display("FAIL mvn_lsl4: got %h expected %h", alu_result_out, 32'hFFFF_F00F); end
    // Store: address = rn + zext(12-bit offset); store value = rm.
    execute_command = 4'b0010; mem_write_in = 1'b1; val_rn = 32'h1000;
    val_rm = 32'hDEAD_BEEF; shift_operand = 12'hFFF;
    step();
    n_checks++; if (alu_result_out !== 32'h1FFF) begin n_fail++; $display("FAIL str_addr: got %h expected %h", alu_result_out, 32'h1FFF); end
    n_checks++; if (store_val_out !== 32'hDEAD_BEEF || mem_write_out !== 1'b1) begin n_fail++; $display("FAIL str_data: got %h/%b expected deadbeef/1", store_val_out, mem_write_out); end
    execute_command = 4'b1111; mem_write_in = 1'b0;
    step();
    n_checks++; if (alu_result_out !== 32'h0) begin n_fail++; $display("FAIL bad_cmd: got %h expected %h", alu_result_out, 32'h0); end
  endtask

  task automatic test_branch();
    set_idle();
    pc_in = 32'h100; signed_imm = 24'hFFFFFE; branch_taken_in = 1'b1;
    #1;
    n_checks++; if (branch_addr !== 32'hF8 || branch_taken !== 1'b1) begin n_fail++; $display("FAIL branch_back: got %h/%b expected f8/1", branch_addr, branch_taken); end
    signed_imm = 24'h000010; branch_taken_in = 1'b0;
    #1;
    n_checks++; if (branch_addr !== 32'h140 || branch_taken !== 1'b0) begin n_fail++; $display("FAIL branch_fwd: got %h/%b expected 140/0", branch_addr, branch_taken); end
  endtask

  task automatic test_freeze();
    set_idle();
    execute_command = 4'b0100; status_write_enable_in = 1'b1; val_rn = 32'd5;
    immediate = 1'b1; shift_operand = 12'h003; dest_reg_in = 4'd7; wb_enable_in = 1'b1;
    step();
    n_checks++; if (alu_result_out !== 32'd2 || status_out !== 4'b0010) begin n_fail++; $display("FAIL pre_freeze: got %h/%b expected 2/0010", alu_result_out, status_out); end
    freeze = 1'b1; execute_command = 4'b0010; val_rn = 32'hFFFF_FFFF; dest_reg_in = 4'd9;
    wb_enable_in = 1'b0; mem_read_in = 1'b1; branch_taken_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (alu_result_out !== 32'd2 || dest_reg_out !== 4'd7 || wb_enable_out !== 1'b1 || mem_read_out !== 1'b0) begin n_fail++; $display("FAIL freeze_hold[%0d]: got %h/%h/%b/%b expected 2/7/1/0", i, alu_result_out, dest_reg_out, wb_enable_out, mem_read_out); end
      n_checks++; if (status_out !== 4'b0010) begin n_fail++; $display("FAIL freeze_nzcv[%0d]: got %b expected %b", i, status_out, 4'b0010); end
    end
    n_checks++; if (branch_taken !== 1'b1) begin n_fail++; $display("FAIL freeze_branch: got %b expected 1", branch_taken); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    n_checks++; if (alu_result_out !== 32'h0 || dest_reg_out !== 4'h0 || wb_enable_out !== 1'b0 || status_out !== 4'b0000) begin n_fail++; $display("FAIL freeze_reset: got %h/%h/%b/%b expected 0/0/0/0000", alu_result_out, dest_reg_out, wb_enable_out, status_out); end
  endtask

  task automatic test_bubble();
    set_idle();
    execute_command = 4'b0100; status_write_enable_in = 1'b1; val_rn = 32'd1; val_rm = 32'd2;
    step();
    n_checks++; if (status_out !== 4'b1000) begin n_fail++; $display("FAIL bubble_setup: got %b expected %b", status_out, 4'b1000); end
    set_idle();
    val_rn = 32'h1234; val_rm = 32'h5678;
    step();
    n_checks++; if (alu_result_out !== 32'h0 || {mem_read_out, mem_write_out, wb_enable_out} !== 3'b000 || status_out !== 4'b1000) begin n_fail++; $display("FAIL bubble: got %h/%b/%b expected 0/000/1000", alu_result_out, {mem_read_out, mem_write_out, wb_enable_out}, status_out); end
  endtask

  task automatic test_forwarding();
    logic [31:0] exp_res;
    logic [31:0] exp_mov;
    set_idle();
`ifdef EXE_FORWARDING_EN
    exp_res = 32'h101;
    exp_mov = 32'hAA;
`else
    exp_res = 32'h11;
    exp_mov = 32'h55;
`endif
    execute_command = 4'b0010; val_rn = 32'h10; immediate = 1'b1; shift_operand = 12'h001;
    sel_src1 = 2'b01; mem_fwd_val = 32'h100;
    step();
    n_checks++; if (alu_result_out !== exp_res) begin n_fail++; $display("FAIL fwd_src1: got %h expected %h", alu_result_out, exp_res); end
    execute_command = 4'b0001; immediate = 1'b0; shift_operand = 12'h000;
    sel_src1 = 2'b00; sel_src2 = 2'b10; val_rm = 32'h55; wb_fwd_val = 32'hAA;
    step();
    n_checks++; if (alu_result_out !== exp_mov || store_val_out !== exp_mov) begin n_fail++; $display("FAIL fwd_src2: got %h/%h expected %h", alu_result_out, store_val_out, exp_mov); end
    sel_src2 = 2'b11;
    step();
    n_checks++; if (alu_result_out !== 32'h55) begin n_fail++; $display("FAIL fwd_sel11: got %h expected %h", alu_result_out, 32'h55); end
  endtask

  initial begin
    set_idle();
    rst = 1'b0;
    test_reset();
    test_add();
    test_sub_adc();
    test_overflow();
    test_val2();
    test_branch();
    test_freeze();
    test_bubble();
    test_forwarding();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
